// File: rtl/watch_pkg.sv
// Shared definitions for the time-of-day block: mode encoding and field limits.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear, enable and a wrap carry-out.
module mod_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    assign carry = en && !clr && (count == WIDTH'(MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= carry ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/time_of_day.sv
// 24 h time-of-day counter with RUN/SET_HOUR/SET_MIN button control.
// Define TIME_12H_EN to produce a 12 h display hour and pm flag.
module time_of_day
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] disp_hour,
    output logic       pm,
    output logic [1:0] mode,
    output logic       day_tick
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    mode_t           state_q, state_d;
    logic [PW-1:0]   presc_q;
    logic            run, inc_ok, sec_tick;
    logic            sec_clr, presc_clr;
    logic            sec_wrap, min_wrap, hour_wrap;
    logic            min_en, hour_en;
    logic [4:0]      hour_next, disp_d;
    logic            pm_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mode_btn) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                default:  state_d = RUN;
            endcase
        end
    end

    assign run    = (state_q == RUN);
    assign inc_ok = inc_btn && !mode_btn;

    // The prescaler also stays clear on the SET_MIN->RUN edge so the first second is full length.
    assign presc_clr = !run || mode_btn;
    assign sec_clr   = (state_d != RUN);
    assign sec_tick  = run && !mode_btn && (presc_q == PRE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              presc_q <= '0;
        else if (presc_clr || sec_tick)        presc_q <= '0;
        else                                   presc_q <= presc_q + PW'(1);
    end

    assign min_en  = (run && sec_wrap) || (state_q == SET_MIN  && inc_ok);
    assign hour_en = (run && min_wrap) || (state_q == SET_HOUR && inc_ok);

    mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .clr(sec_clr), .en(sec_tick), .count(sec), .carry(sec_wrap)
    );

    mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .clr(1'b0), .en(min_en), .count(min), .carry(min_wrap)
    );

    mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .clr(1'b0), .en(hour_en), .count(hour), .carry(hour_wrap)
    );

    // Display registers track the hour counter's next value so they update on the same edge.
    assign hour_next = hour_wrap ? '0 : (hour_en ? hour + 5'd1 : hour);

`ifdef TIME_12H_EN
    localparam logic [4:0] DISP_RST = 5'd12;
    always_comb begin
        disp_d = hour_next;
        pm_d   = (hour_next >= 5'd12);
        if (hour_next == 5'd0 || hour_next == 5'd12) disp_d = 5'd12;
        else if (hour_next > 5'd12)                   disp_d = hour_next - 5'd12;
    end
`else
    localparam logic [4:0] DISP_RST = 5'd0;
    always_comb begin
        disp_d = hour_next;
        pm_d   = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_hour <= DISP_RST;
            pm        <= 1'b0;
            day_tick  <= 1'b0;
        end else begin
            disp_hour <= disp_d;
            pm        <= pm_d;
            day_tick  <= run && hour_wrap;
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_time_of_day.sv
// Directed plus random bench for time_of_day against a seconds-of-day reference model.
module tb_time_of_day;

    localparam int unsigned CLK_HZ = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] sec, min;
    logic [4:0] hour, disp_hour;
    logic       pm, day_tick;
    logic [1:0] mode;

    int n_pass = 0;
    int n_chk  = 0;
    int day_seen = 0;

    // Reference state: mode 0/1/2, seconds since midnight, prescaler phase.
    int m_mode, m_tod, m_pre;
    bit m_day;

    always #5 clk = ~clk;

    time_of_day #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec(sec), .min(min), .hour(hour), .disp_hour(disp_hour),
        .pm(pm), .mode(mode), .day_tick(day_tick)
    );

    function automatic void model_reset();
        m_mode = 0; m_tod = 0; m_pre = 0; m_day = 0;
    endfunction

    function automatic void model_step(bit mb, bit ib);
        int h, m;
        m_day = 0;
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        if (mb) begin
            m_mode = (m_mode + 1) % 3;
            m_pre  = 0;
            m_tod  = h * 3600 + m * 60;
        end else if (m_mode == 0) begin
            if (m_pre == CLK_HZ - 1) begin
                m_pre = 0;
                m_tod = (m_tod + 1) % 86400;
                if (m_tod == 0) m_day = 1;
            end else begin
                m_pre++;
            end
        end else if (ib) begin
            if (m_mode == 1) m_tod = ((h + 1) % 24) * 3600 + m * 60;
            else             m_tod = h * 3600 + ((m + 1) % 60) * 60;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic check_all();
        int h, ed, ep;
        h  = m_tod / 3600;
`ifdef TIME_12H_EN
        ed = (h % 12 == 0) ? 12 : h % 12;
        ep = (h >= 12) ? 1 : 0;
`else
        ed = h;
        ep = 0;
`endif
        check("sec",       32'(sec),       32'(m_tod % 60));
        check("min",       32'(min),       32'((m_tod / 60) % 60));
        check("hour",      32'(hour),      32'(h));
        check("disp_hour", 32'(disp_hour), 32'(ed));
        check("pm",        32'(pm),        32'(ep));
        check("mode",      32'(mode),      32'(m_mode));
        check("day_tick",  32'(day_tick),  32'(m_day));
    endtask

    task automatic cycle(input bit mb, input bit ib);
        mode_btn = mb;
        inc_btn  = ib;
        @(posedge clk);
        model_step(mb, ib);
        #1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        check_all();
        if (day_tick === 1'b1) day_seen++;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst = 1'b1;

        // Free-run from reset: 12 cycles is three seconds.
        repeat (12) cycle(1'b0, 1'b0);
        check("r028_sec", 32'(sec), 32'd3);
        check("r028_day", 32'(day_seen), 32'd0);

        // Set 23:59, resume, cross midnight.
        cycle(1'b1, 1'b0);
        repeat (23) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (59) cycle(1'b0, 1'b1);
        check("set_hour", 32'(hour), 32'd23);
        check("set_min",  32'(min),  32'd59);
        cycle(1'b1, 1'b0);
        day_seen = 0;
        repeat (240) cycle(1'b0, 1'b0);
        check("r029_days", 32'(day_seen), 32'd1);
        check("r029_hms", {11'd0, hour, min, sec}, 32'd0);

        // Simultaneous buttons in RUN: mode wins.
        cycle(1'b1, 1'b1);
        check("r031_mode", 32'(mode), 32'd1);
        check("r031_hour", 32'(hour), 32'd0);

        // Hour wrap while setting never produces a day tick.
        repeat (23) cycle(1'b0, 1'b1);
        check("r030_pre", 32'(hour), 32'd23);
        cycle(1'b0, 1'b1);
        check("r030_hour", 32'(hour), 32'd0);
        check("r030_day",  32'(day_tick), 32'd0);
        check("r030_min",  32'(min), 32'd0);

        // Asynchronous reset in SET_MIN at 10:20.
        repeat (10) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b1);
        check("r032_hm",   32'(hour) * 100 + 32'(min), 32'd1020);
        check("r032_mode", 32'(mode), 32'd2);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1 check_all();
        check("r032_rst", {11'd0, hour, min, sec}, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Display hour at 0, 12 and 13.
        cycle(1'b1, 1'b0);
`ifdef TIME_12H_EN
        check("r033_d0", 32'(disp_hour), 32'd12);
        check("r033_p0", 32'(pm), 32'd0);
        repeat (12) cycle(1'b0, 1'b1);
        check("r033_d12", 32'(disp_hour), 32'd12);
        check("r033_p12", 32'(pm), 32'd1);
        cycle(1'b0, 1'b1);
        check("r033_d13", 32'(disp_hour), 32'd1);
        check("r033_p13", 32'(pm), 32'd1);
`else
        repeat (13) cycle(1'b0, 1'b1);
        check("r033_d13", 32'(disp_hour), 32'd13);
        check("r033_p13", 32'(pm), 32'd0);
`endif
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        // Random button traffic across all modes.
        repeat (2000) cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/time_of_day.md
TIME_OF_DAY -- requirements
Module: time_of_day

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1000, meaning clk cycles per second (legal range 1..2^20).
REQ-002 SHALL have port clk, input, 1 bit, system clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset: asynchronous, active-low.
REQ-004 SHALL have port mode_btn, input, 1 bit, debounced single-cycle pulse that advances the set mode.
REQ-005 SHALL have port inc_btn, input, 1 bit, debounced single-cycle pulse that increments the selected field.
REQ-006 SHALL have port sec, output, 6 bits, seconds 0..59.
REQ-007 SHALL have port min, output, 6 bits, minutes 0..59.
REQ-008 SHALL have port hour, output, 5 bits, hours 0..23 (internal 24 h count).
REQ-009 SHALL have port disp_hour, output, 5 bits, display hour.
REQ-010 SHALL have port pm, output, 1 bit, afternoon flag.
REQ-011 SHALL have port mode, output, 2 bits, current FSM state code.
REQ-012 SHALL have port day_tick, output, 1 bit, one-cycle pulse at midnight rollover; drives the downstream date counter clock/enable.

Function
REQ-013 SHALL contain prescaler 0..CLK_HZ-1; sec_tick asserted in the cycle the prescaler equals CLK_HZ-1, prescaler then wraps to 0; CLK_HZ=1 gives sec_tick every cycle.
REQ-014 SHALL have FSM states RUN=0, SET_HOUR=1, SET_MIN=2; mode_btn moves RUN->SET_HOUR->SET_MIN->RUN; no other transitions.
REQ-015 In RUN, on sec_tick: sec increments; sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0 completes the rollover.
REQ-016 SHALL assert day_tick for exactly one cycle, registered, in the same cycle that hour/min/sec read 00:00:00 after the 23:59:59 rollover.
REQ-017 In SET_HOUR, inc_btn increments hour with wrap 23->0; in SET_MIN, inc_btn increments min with wrap 59->0; these wraps never carry and never assert day_tick.
REQ-018 In SET_HOUR and SET_MIN: sec is held at 0, the prescaler is held at 0, and sec_tick is suppressed.
REQ-019 On SET_MIN->RUN, counting resumes with a full CLK_HZ-cycle second starting from the cycle after the transition.
REQ-020 inc_btn in RUN SHALL be ignored; if mode_btn and inc_btn are asserted in the same cycle, mode_btn wins and inc_btn is ignored.
REQ-021 All outputs SHALL be registered; a button effect is visible one cycle after the pulse.

Reset
REQ-022 While rst=0: sec=0, min=0, hour=0, prescaler=0, mode=RUN, day_tick=0; disp_hour and pm take their values for hour=0 per REQ-023/REQ-024.
REQ-023 Reset mid-operation, including in a set state, SHALL abort immediately with no day_tick; counting restarts on the first clk edge after rst rises.

Configuration
REQ-024 With macro TIME_12H_EN defined: disp_hour = 12 for hour 0 or 12, otherwise hour mod 12; pm = 1 for hour 12..23.
REQ-025 Without TIME_12H_EN: disp_hour = hour and pm is held at 0; ports are unchanged.

Structure
REQ-026 Shared package watch_pkg SHALL hold the mode state encoding and the constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
REQ-027 SHALL instantiate sub-module mod_counter (parameterised max, enable, wrap-to-0, carry-out) for each of sec, min and hour.

Verification (CLK_HZ=4 unless stated)
REQ-028 Release reset, run 12 cycles -> sec=3, min=0, hour=0; day_tick never asserted.
REQ-029 Set the time to 23:59, return to RUN, run 240 cycles -> exactly one day_tick pulse, coincident with 00:00:00.
REQ-030 In SET_HOUR from hour=23, pulse inc_btn -> hour=0, day_tick=0, min unchanged.
REQ-031 Pulse mode_btn and inc_btn together in RUN -> mode=SET_HOUR, hour unchanged.
REQ-032 Assert rst in SET_MIN at 10:20 -> 00:00:00, mode=RUN, no day_tick.
REQ-033 With TIME_12H_EN defined, hour=0/12/13 -> disp_hour=12/12/1, pm=0/1/1; without the macro, hour=13 -> disp_hour=13, pm=0.
